// File: rtl/clk_period_meter.sv
// Measures high time, low time and period of a slow asynchronous square wave in clk cycles,
// with frequency-lock and loss-of-signal indication.
`timescale 1ns/1ps
module clk_period_meter #(
    parameter int CNT_W       = 20,
    parameter int EXPECT_HALF = 250000,
    parameter int TOL         = 16,
    parameter int LOCK_COUNT  = 4,
    parameter int TIMEOUT     = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] low_time,
    output logic [CNT_W:0]   period,
    output logic             meas_valid,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int LC_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] EXP_V    = CNT_W'(EXPECT_HALF);
    localparam logic [CNT_W-1:0] TOL_V    = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [LC_W-1:0]  LOCK_MAX = LC_W'(LOCK_COUNT);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_TIMEOUT} state_t;

    state_t            state, state_next;
    logic              sig_meta, sig_s, sig_d;
    logic              edge_det;
    logic              timeout_hit;
    logic              capture;
    logic              enter_timeout;
    logic              high_seen;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  half;
    logic [LC_W-1:0]   lock_cnt;
    logic [LC_W-1:0]   lock_next;

    // Half-period within tolerance; the difference is formed one bit wider so it cannot wrap.
    function automatic logic in_tol(input logic [CNT_W-1:0] h);
        logic signed [CNT_W:0] diff;
        diff = $signed({1'b0, h}) - $signed({1'b0, EXP_V});
        if (diff < 0) diff = -diff;
        return diff <= $signed({1'b0, TOL_V});
    endfunction

    function automatic logic [LC_W-1:0] sat_inc(input logic [LC_W-1:0] v);
        return (v == LOCK_MAX) ? v : v + 1'b1;
    endfunction

    // Synchronizer and edge detect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_meta <= 1'b0;
            sig_s    <= 1'b0;
            sig_d    <= 1'b0;
        end else begin
            sig_meta <= sig_in;
            sig_s    <= sig_meta;
            sig_d    <= sig_s;
        end
    end

    assign edge_det    = sig_s ^ sig_d;
    assign half        = cnt + 1'b1;
    assign timeout_hit = (cnt == TO_LAST) && !edge_det;
    assign lock_next   = sat_inc(lock_cnt);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next    = state;
        capture       = 1'b0;
        enter_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (edge_det) begin
                    state_next = S_ARMED;
                end else if (timeout_hit) begin
                    state_next    = S_TIMEOUT;
                    enter_timeout = 1'b1;
                end
            end
            S_ARMED: begin
                if (edge_det) begin
                    capture = 1'b1;
                end else if (timeout_hit) begin
                    state_next    = S_TIMEOUT;
                    enter_timeout = 1'b1;
                end
            end
            S_TIMEOUT: begin
                if (edge_det) state_next = S_ARMED;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Counter, capture registers and lock tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt          <= '0;
            high_time    <= '0;
            low_time     <= '0;
            period       <= '0;
            meas_valid   <= 1'b0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
            high_seen    <= 1'b0;
            lock_cnt     <= '0;
        end else begin
            meas_valid   <= 1'b0;
            period_valid <= 1'b0;
            // Saturate so a dead input parked in TIMEOUT never wraps back into range.
            if (edge_det)            cnt <= '0;
            else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;

            if (capture) begin
                meas_valid <= 1'b1;
                timeout    <= 1'b0;
                if (!sig_s) begin
                    high_time <= half;
                    high_seen <= 1'b1;
                end else begin
                    low_time <= half;
                    if (high_seen) begin
                        period       <= {1'b0, high_time} + {1'b0, half};
                        period_valid <= 1'b1;
                    end
                end
                if (in_tol(half)) begin
                    lock_cnt <= lock_next;
                    locked   <= (lock_next == LOCK_MAX);
                end else begin
                    lock_cnt <= '0;
                    locked   <= 1'b0;
                end
            end

            if (enter_timeout) begin
                timeout   <= 1'b1;
                locked    <= 1'b0;
                lock_cnt  <= '0;
                high_seen <= 1'b0;
            end
        end
    end

endmodule
